// File: rtl/ss_rfm_tracker_pkg.sv
// Shared types and helpers for the Space-Saving row-hammer tracker.
package ss_rfm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ISSUE  = 2'd2,
    UPDATE = 2'd3
  } state_e;

  localparam int NRR_MODE_ZERO = 0;
  localparam int NRR_MODE_MIN  = 1;

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ss_rfm_tracker_if.sv
// Command-decoder / NRR-issuer side bundle of the row-hammer tracker.
interface ss_rfm_tracker_if #(
  parameter int ADDR_SIZE = 18,
  parameter int CNT_SIZE  = 16,
  parameter int RAA_W     = 8
);
  logic                 act_cmd;
  logic [ADDR_SIZE-1:0] act_addr;
  logic                 rfm_cmd;
  logic                 nrr_valid;
  logic                 nrr_ready;
  logic [ADDR_SIZE-1:0] nrr_addr;
  logic [CNT_SIZE-1:0]  nrr_cnt;
  logic                 rfm_req;
  logic [RAA_W-1:0]     raa_cnt;
  logic                 rfm_drop;
  logic                 busy;

  // Command decoder and NRR issuer drive commands and ready.
  modport master (
    output act_cmd, act_addr, rfm_cmd, nrr_ready,
    input  nrr_valid, nrr_addr, nrr_cnt, rfm_req, raa_cnt, rfm_drop, busy
  );

  // The tracker consumes commands and produces NRR requests/status.
  modport slave (
    input  act_cmd, act_addr, rfm_cmd, nrr_ready,
    output nrr_valid, nrr_addr, nrr_cnt, rfm_req, raa_cnt, rfm_drop, busy
  );
endinterface

// File: rtl/ss_rfm_tracker_argsel.sv
// Valid-masked argmin/argmax over a small table; lowest index wins ties.
module ss_rfm_argsel #(
  parameter int N        = 16,
  parameter int W        = 16,
  parameter bit MODE_MAX = 1'b0
) (
  input  logic [N-1:0]         vld,
  input  logic [W-1:0]         val [N],
  output logic [$clog2(N)-1:0] idx,
  output logic [W-1:0]         value,
  output logic                 any_valid
);
  localparam int IDX_W = $clog2(N);

  // Linear scan; strict compare keeps the earlier index on equal values.
  always_comb begin
    idx       = '0;
    value     = '0;
    any_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vld[i]) begin
        if (!any_valid || (MODE_MAX ? (val[i] > value) : (val[i] < value))) begin
          idx       = IDX_W'(i);
          value     = val[i];
          any_valid = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/ss_rfm_tracker.sv
// Per-bank Space-Saving row-hammer tracker with RAA counter and RFM-driven NRR issue.
module ss_rfm_tracker
  import ss_rfm_pkg::*;
#(
  parameter int NUM_ENTRY = 16,
  parameter int ADDR_SIZE = 18,
  parameter int CNT_SIZE  = 16,
  parameter int RFM_TH    = 64,
  parameter int NRR_MODE  = 0
) (
  input logic             clk,
  input logic             rst,
  ss_rfm_tracker_if.slave bus
);
  localparam int IDX_W   = $clog2(NUM_ENTRY);
  localparam int RAA_MAX = 2 * RFM_TH;
  localparam int RAA_W   = $clog2(2 * RFM_TH + 1);
  localparam logic [CNT_SIZE-1:0] CNT_MAX = '1;
  localparam logic [RAA_W:0]      TH_X    = (RAA_W + 1)'(RFM_TH);
  localparam logic [RAA_W:0]      MAX_X   = (RAA_W + 1)'(RAA_MAX);
  localparam logic [RAA_W-1:0]    TH_R    = RAA_W'(RFM_TH);

  function automatic logic [CNT_SIZE-1:0] sat_cnt(input logic [CNT_SIZE-1:0] v);
    return CNT_SIZE'(sat_inc(32'(v), 32'(CNT_MAX)));
  endfunction

  logic [NUM_ENTRY-1:0] vld_q, vld_d;
  logic [ADDR_SIZE-1:0] addr_q [NUM_ENTRY];
  logic [ADDR_SIZE-1:0] addr_d [NUM_ENTRY];
  logic [CNT_SIZE-1:0]  cnt_q  [NUM_ENTRY];
  logic [CNT_SIZE-1:0]  cnt_d  [NUM_ENTRY];

  logic                 hit, free;
  logic [IDX_W-1:0]     hit_idx, free_idx;
  logic [IDX_W-1:0]     min_idx, max_idx;
  logic [CNT_SIZE-1:0]  min_val, max_val, policy;
  logic                 min_any, max_any;

  logic [RAA_W-1:0]     raa_q, raa_d;
  logic [RAA_W:0]       raa_sum;

  state_e               state_q, state_d;
  logic                 pend_q, pend_d, drop_q, drop_d;
  logic [IDX_W-1:0]     sel_idx_q, sel_idx_d;
  logic [ADDR_SIZE-1:0] nrr_addr_q, nrr_addr_d;
  logic [CNT_SIZE-1:0]  nrr_cnt_q, nrr_cnt_d;

  ss_rfm_argsel #(.N(NUM_ENTRY), .W(CNT_SIZE), .MODE_MAX(1'b0)) u_min (
    .vld(vld_q), .val(cnt_q), .idx(min_idx), .value(min_val), .any_valid(min_any)
  );

  ss_rfm_argsel #(.N(NUM_ENTRY), .W(CNT_SIZE), .MODE_MAX(1'b1)) u_max (
    .vld(vld_q), .val(cnt_q), .idx(max_idx), .value(max_val), .any_valid(max_any)
  );

  // Find the lowest-index entry holding the ACT row and the lowest-index free slot.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (vld_q[i] && addr_q[i] == bus.act_addr && !hit) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!vld_q[i] && !free) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Table update: mitigation policy first, then the ACT on top so a hit lands on the new base.
  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    policy = (NRR_MODE == NRR_MODE_MIN && min_any) ? min_val : '0;
    if (state_q == UPDATE) cnt_d[sel_idx_q] = policy;
    if (bus.act_cmd) begin
      if (hit) begin
        cnt_d[hit_idx] = sat_cnt(cnt_d[hit_idx]);
      end else if (free) begin
        vld_d[free_idx]  = 1'b1;
        addr_d[free_idx] = bus.act_addr;
        cnt_d[free_idx]  = CNT_SIZE'(1);
      end else begin
        addr_d[min_idx] = bus.act_addr;
        cnt_d[min_idx]  = sat_cnt(min_val);
      end
    end
  end

  // Table registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < NUM_ENTRY; i++) begin
        addr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  // RAA: add the ACT, subtract one RFM worth (floor 0), then clamp at the ceiling.
  always_comb begin
    raa_sum = {1'b0, raa_q} + {{RAA_W{1'b0}}, bus.act_cmd};
    if (bus.rfm_cmd) raa_sum = (raa_sum >= TH_X) ? raa_sum - TH_X : '0;
    raa_d = (raa_sum > MAX_X) ? MAX_X[RAA_W-1:0] : raa_sum[RAA_W-1:0];
  end

  // NRR FSM next state, capture values, pending slot and drop detection.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    drop_d     = 1'b0;
    sel_idx_d  = sel_idx_q;
    nrr_addr_d = nrr_addr_q;
    nrr_cnt_d  = nrr_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.rfm_cmd || pend_q) begin
          state_d = SELECT;
          pend_d  = bus.rfm_cmd && pend_q;
        end
      end
      SELECT: begin
        if (max_any) begin
          state_d    = ISSUE;
          sel_idx_d  = max_idx;
          nrr_addr_d = addr_q[max_idx];
          nrr_cnt_d  = max_val;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE:   if (bus.nrr_ready) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && bus.rfm_cmd) begin
      if (pend_q) drop_d = 1'b1;
      else        pend_d = 1'b1;
    end
  end

  // Control and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      drop_q     <= 1'b0;
      raa_q      <= '0;
      sel_idx_q  <= '0;
      nrr_addr_q <= '0;
      nrr_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      raa_q      <= raa_d;
      sel_idx_q  <= sel_idx_d;
      nrr_addr_q <= nrr_addr_d;
      nrr_cnt_q  <= nrr_cnt_d;
    end
  end

  assign bus.nrr_valid = (state_q == ISSUE);
  assign bus.nrr_addr  = nrr_addr_q;
  assign bus.nrr_cnt   = nrr_cnt_q;
  assign bus.rfm_req   = (raa_q >= TH_R);
  assign bus.raa_cnt   = raa_q;
  assign bus.rfm_drop  = drop_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_ss_rfm_tracker.sv
// Bench for ss_rfm_tracker: default, min-policy and 4-bit-counter instances share one stimulus.
module tb_ss_rfm_tracker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        act_cmd = 1'b0;
  logic [17:0] act_addr = '0;
  logic        rfm_cmd = 1'b0;
  logic        nrr_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] cnt;
  } nrr_exp_t;
  nrr_exp_t sb_q[$];

  typedef struct {
    int n_act;
    bit rfm;
    bit rfm_act;
    int exp_raa;
    bit exp_req;
    bit exp_drop;
  } raa_vec_t;
  raa_vec_t vecs[6];

  always #5 clk = ~clk;

  ss_rfm_tracker_if #(.ADDR_SIZE(18), .CNT_SIZE(16), .RAA_W(8)) if0 ();
  ss_rfm_tracker_if #(.ADDR_SIZE(18), .CNT_SIZE(16), .RAA_W(8)) if1 ();
  ss_rfm_tracker_if #(.ADDR_SIZE(18), .CNT_SIZE(4),  .RAA_W(8)) if2 ();

  assign if0.act_cmd = act_cmd;   assign if1.act_cmd = act_cmd;   assign if2.act_cmd = act_cmd;
  assign if0.act_addr = act_addr; assign if1.act_addr = act_addr; assign if2.act_addr = act_addr;
  assign if0.rfm_cmd = rfm_cmd;   assign if1.rfm_cmd = rfm_cmd;   assign if2.rfm_cmd = rfm_cmd;
  assign if0.nrr_ready = nrr_ready; assign if1.nrr_ready = nrr_ready; assign if2.nrr_ready = nrr_ready;

  ss_rfm_tracker #(.NRR_MODE(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  ss_rfm_tracker #(.NRR_MODE(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  ss_rfm_tracker #(.CNT_SIZE(4), .NRR_MODE(0)) u2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit a, input logic [17:0] ad, input bit r, input bit rdy);
    act_cmd = a; act_addr = ad; rfm_cmd = r; nrr_ready = rdy;
    @(posedge clk); #1;
    act_cmd = 1'b0; rfm_cmd = 1'b0; nrr_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor on u0: pop on each new NRR, demand stability while stalled.
  bit          mon_pv = 1'b0;
  bit          mon_pr = 1'b0;
  logic [17:0] mon_pa = '0;
  logic [15:0] mon_pc = '0;
  always @(negedge clk) begin
    if (rst) begin
      mon_pv = 1'b0;
    end else begin
      if (if0.nrr_valid && !mon_pv) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected_nrr actual_addr=%0d required=none", if0.nrr_addr);
        end else begin
          nrr_exp_t e;
          e = sb_q.pop_front();
          check("sb_nrr_addr", 64'(if0.nrr_addr), 64'(e.addr));
          check("sb_nrr_cnt", 64'(if0.nrr_cnt), 64'(e.cnt));
        end
      end else if (if0.nrr_valid && mon_pv && !mon_pr) begin
        check("sb_hold_addr", 64'(if0.nrr_addr), 64'(mon_pa));
        check("sb_hold_cnt", 64'(if0.nrr_cnt), 64'(mon_pc));
      end
      mon_pv = if0.nrr_valid;
      mon_pr = nrr_ready;
      mon_pa = if0.nrr_addr;
      mon_pc = if0.nrr_cnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    //              n_act rfm  r+a  raa  req  drop
    vecs[0] = '{63,  1'b0, 1'b0, 63,  1'b0, 1'b0};
    vecs[1] = '{1,   1'b0, 1'b0, 64,  1'b1, 1'b0};
    vecs[2] = '{200, 1'b0, 1'b0, 128, 1'b1, 1'b0};
    vecs[3] = '{0,   1'b1, 1'b0, 64,  1'b1, 1'b0};
    vecs[4] = '{0,   1'b1, 1'b1, 1,   1'b0, 1'b0};
    vecs[5] = '{0,   1'b1, 1'b0, 0,   1'b0, 1'b1};

    do_reset();
    check("rst_nrr_valid", 64'(if0.nrr_valid), 64'd0);
    check("rst_raa", 64'(if0.raa_cnt), 64'd0);
    check("rst_rfm_req", 64'(if0.rfm_req), 64'd0);
    check("rst_busy", 64'(if0.busy), 64'd0);
    check("rst_drop", 64'(if0.rfm_drop), 64'd0);
    check("rst_vld", 64'(u0.vld_q), 64'd0);

    // RAA vectors, all ACTs to row 50; ready held low so the first RFM parks in ISSUE.
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < vecs[v].n_act; k++) cyc(1'b1, 18'd50, 1'b0, 1'b0);
      if (vecs[v].rfm) begin
        if (v == 3) sb_q.push_back('{18'd50, 16'd264});
        cyc(vecs[v].rfm_act, 18'd50, 1'b1, 1'b0);
      end
      check($sformatf("raa_v%0d", v), 64'(if0.raa_cnt), 64'(vecs[v].exp_raa));
      check($sformatf("req_v%0d", v), 64'(if0.rfm_req), 64'(vecs[v].exp_req));
      check($sformatf("drop_v%0d", v), 64'(if0.rfm_drop), 64'(vecs[v].exp_drop));
    end
    check("raa_row_cnt", 64'(u0.cnt_q[0]), 64'd265);
    check("cnt4_sat_after_raa", 64'(u2.cnt_q[0]), 64'd15);
    check("issue_before_rst", 64'(if0.nrr_valid), 64'd1);

    // Reset while in ISSUE.
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_issue_valid", 64'(if0.nrr_valid), 64'd0);
    check("rst_issue_vld", 64'(u0.vld_q), 64'd0);
    check("rst_issue_vld_c4", 64'(u2.vld_q), 64'd0);
    check("rst_issue_busy", 64'(if0.busy), 64'd0);
    check("rst_issue_raa", 64'(if0.raa_cnt), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill: rows 0..15 once, row 3 four more times, then row 100 evicts entry 0.
    for (int r = 0; r < 16; r++) cyc(1'b1, 18'(r), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b1, 18'd3, 1'b0, 1'b0);
    check("fill_vld", 64'(u0.vld_q), 64'hFFFF);
    check("fill_cnt3", 64'(u0.cnt_q[3]), 64'd5);
    check("fill_cnt0", 64'(u0.cnt_q[0]), 64'd1);
    check("fill_addr15", 64'(u0.addr_q[15]), 64'd15);
    cyc(1'b1, 18'd100, 1'b0, 1'b0);
    check("evict_addr0", 64'(u0.addr_q[0]), 64'd100);
    check("evict_cnt0", 64'(u0.cnt_q[0]), 64'd2);
    check("evict_cnt0_m1", 64'(u1.cnt_q[0]), 64'd2);
    check("fill_raa", 64'(if0.raa_cnt), 64'd21);
    check("fill_req", 64'(if0.rfm_req), 64'd0);

    // First NRR: two-cycle latency, stall with extra RFMs while waiting.
    sb_q.push_back('{18'd3, 16'd5});
    cyc(1'b0, 18'd0, 1'b1, 1'b0);
    check("nrr_lat1_valid", 64'(if0.nrr_valid), 64'd0);
    check("nrr_lat1_busy", 64'(if0.busy), 64'd1);
    cyc(1'b0, 18'd0, 1'b0, 1'b0);
    check("nrr_lat2_valid", 64'(if0.nrr_valid), 64'd1);
    for (int k = 0; k < 10; k++) begin
      if (k == 2) sb_q.push_back('{18'd100, 16'd2});
      cyc(1'b0, 18'd0, (k == 2 || k == 4), 1'b0);
      check("hold_valid", 64'(if0.nrr_valid), 64'd1);
      check("hold_addr", 64'(if0.nrr_addr), 64'd3);
      check("hold_cnt", 64'(if0.nrr_cnt), 64'd5);
      if (k == 2) check("pend_no_drop", 64'(if0.rfm_drop), 64'd0);
      if (k == 4) check("second_rfm_drop", 64'(if0.rfm_drop), 64'd1);
      if (k == 5) check("drop_pulse_end", 64'(if0.rfm_drop), 64'd0);
    end
    cyc(1'b0, 18'd0, 1'b0, 1'b1);
    check("update_valid", 64'(if0.nrr_valid), 64'd0);
    check("update_busy", 64'(if0.busy), 64'd1);
    cyc(1'b0, 18'd0, 1'b0, 1'b0);
    check("mode0_cnt3", 64'(u0.cnt_q[3]), 64'd0);
    check("mode1_cnt3", 64'(u1.cnt_q[3]), 64'd1);

    // Pending request re-enters SELECT after UPDATE.
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      cyc(1'b0, 18'd0, 1'b0, 1'b0);
      got = if0.nrr_valid;
    end
    check("pending_nrr_seen", 64'(got), 64'd1);
    check("pending_m1_addr", 64'(if1.nrr_addr), 64'd100);
    check("pending_m1_cnt", 64'(if1.nrr_cnt), 64'd2);
    cyc(1'b0, 18'd0, 1'b0, 1'b1);
    cyc(1'b1, 18'd100, 1'b0, 1'b0);
    check("act_in_update_m0", 64'(u0.cnt_q[0]), 64'd1);
    check("act_in_update_m1", 64'(u1.cnt_q[0]), 64'd2);
    check("idle_after_update", 64'(if0.busy), 64'd0);

    // RFM against an empty table issues nothing.
    do_reset();
    cyc(1'b0, 18'd0, 1'b1, 1'b0);
    check("empty_select_busy", 64'(if0.busy), 64'd1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 18'd0, 1'b0, 1'b0);
      check("empty_no_valid", 64'(if0.nrr_valid), 64'd0);
    end
    check("empty_idle", 64'(if0.busy), 64'd0);

    // Counter saturation on the 4-bit instance.
    for (int k = 0; k < 20; k++) cyc(1'b1, 18'd7, 1'b0, 1'b0);
    check("sat_cnt4", 64'(u2.cnt_q[0]), 64'd15);
    check("sat_cnt16", 64'(u0.cnt_q[0]), 64'd20);
    check("sat_addr", 64'(u2.addr_q[0]), 64'd7);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
